pll_phase_ctrl: RTL and testbench
=================================

Name: pll_phase_ctrl

Overview:
Sequencer for the ECP5 EHXPLLL dynamic phase-shift port (PHASESEL, PHASEDIR, PHASESTEP, PHASELOADREG). It accepts "shift output X by N fine steps in direction D" requests and generates correctly timed, active-low PHASESTEP pulses. It waits for PLL lock between steps and tracks the current phase position of each PLL output. It sits between the PLL wrapper and user logic, e.g. an SDRAM read-capture calibration loop.

Parameters:
STEP_W, 6, width of requested step count (max 63 steps per request)
POS_W, 6, width of each tracked phase-position counter
PHASE_MOD, 48, steps per full output period (8 x output divider); positions wrap modulo this
SETUP_CYC, 4, cycles sel/dir are held stable before PHASESTEP falls
PULSE_CYC, 4, cycles PHASESTEP is held low
GAP_CYC, 8, cycles after PHASESTEP rises before the next step or lock check
LOCK_TIMEOUT, 4096, max cycles to wait for lock before flagging error

Ports:
clock  in  1  single system clock
reset  in  1  synchronous, active-high reset
pll_locked  in  1  PLL LOCK output (assumed already synchronised to clock)
req_valid  in  1  request strobe
req_ready  out  1  controller can accept a request
req_sel  in  2  PLL output select (0=CLKOS,1=CLKOS2,2=CLKOS3,3=CLKOP)
req_dir  in  1  0 = advance (+1 per step), 1 = retard (-1 per step)
req_steps  in  STEP_W  number of fine steps
phasesel  out  2  to PLL PHASESEL[1:0]
phasedir  out  1  to PLL PHASEDIR
phasestep  out  1  to PLL PHASESTEP (idle high, active-low pulse)
phaseloadreg  out  1  to PLL PHASELOADREG (held high, never pulsed)
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when a request completes or aborts
err  out  1  sticky lock-timeout flag of the last request
phase_pos  out  4*POS_W  tracked positions; output k at bits [k*POS_W +: POS_W]

Behaviour:
- Reset values: phasesel=0, phasedir=1, phasestep=1, phaseloadreg=1, busy=0, done=0, err=0, phase_pos=0, state IDLE. Reset mid-sequence aborts immediately, with no partial pulse and no done.
- req_ready = (state==IDLE) & pll_locked & ~reset. Handshake completes on a rising edge with req_valid & req_ready. The request fields are latched on that edge; err clears on acceptance.
- States: IDLE, SETUP, PULSE, GAP, LOCKWAIT, FINISH.
- IDLE -> SETUP on accept with steps>0; phasesel/phasedir take the latched sel/dir in the first SETUP cycle. IDLE -> FINISH on accept with steps==0.
- SETUP (SETUP_CYC cycles) -> PULSE.
- PULSE: phasestep=0 for PULSE_CYC cycles. On exit, phasestep returns to 1, the remaining-step count decrements, and phase_pos[sel] updates ±1 mod PHASE_MOD (dir=0: 47 -> 0; dir=1: 0 -> 47).
- GAP (GAP_CYC cycles): if pll_locked is low in the last GAP cycle -> LOCKWAIT. Otherwise -> SETUP if remaining>0, else FINISH.
- LOCKWAIT: counts cycles. Lock high -> continue as GAP exit would. After LOCK_TIMEOUT cycles without lock -> err=1, drop remaining steps, go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE.
- Loss of lock during SETUP/PULSE does not truncate the pulse; it is checked only at GAP end.
- busy=1 in every state except IDLE. sel/dir stay constant throughout a request. phasesel/phasedir keep their last values in IDLE.
- Timing with lock held: accept at edge T. Step k (0-based) has phasestep low in cycles T+1+16k+4 .. T+1+16k+7. done is high in cycle T+1+16N (N=0 gives T+1).
- Timers are a single down-counter sized to clog2(max(LOCK_TIMEOUT, SETUP_CYC, PULSE_CYC, GAP_CYC))+1.

Decomposition:
- Package pll_phase_pkg: state enum, output-select encodings (SEL_CLKOS..SEL_CLKOP), default timing constants.
- One sub-module is natural: pll_phase_timer, a loadable down-counter with a zero flag, reused for the SETUP, PULSE, GAP and LOCKWAIT intervals.

Test Plan:
- Reset then locked=1: req sel=0 dir=0 steps=3 -> exactly 3 phasestep low pulses, each 4 cycles wide on a 16-cycle pitch; done at T+49; phase_pos[0]=3; phasesel=0 and phasedir=0 stable throughout.
- Wrap: steps=1 dir=1 on sel=1 from pos 0 -> phase_pos[1]=47. Then steps=1 dir=0 -> 0. Then dir=0 steps=48 -> returns to 0.
- steps=0 -> no phasestep activity; done at T+1; busy high for one cycle; phase_pos unchanged.
- Drop pll_locked during the 2nd step's PULSE and restore it 100 cycles later -> pulse not truncated, LOCKWAIT entered, remaining step resumes, done, err=0.
- Hold lock low for >4096 cycles after step 1 of 5 -> err=1, done pulse, phase_pos changed by exactly 1, req_ready stays low until lock returns.
- Assert reset mid-PULSE -> next cycle phasestep=1, busy=0, phase_pos=0, no done. req_valid while busy or unlocked is ignored (ready=0) and causes no pulses.

Source files
------------

// File: rtl/pll_phase_pkg.sv
// Shared types and default timing for the ECP5 EHXPLLL dynamic phase-shift sequencer.
package pll_phase_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_GAP,
      ST_LOCKWAIT,
      ST_FINISH
   } state_e;

   // PHASESEL encodings of the EHXPLLL outputs
   localparam logic [1:0] SEL_CLKOS  = 2'd0;
   localparam logic [1:0] SEL_CLKOS2 = 2'd1;
   localparam logic [1:0] SEL_CLKOS3 = 2'd2;
   localparam logic [1:0] SEL_CLKOP  = 2'd3;

   localparam int DEF_STEP_W       = 6;
   localparam int DEF_POS_W        = 6;
   localparam int DEF_PHASE_MOD    = 48;
   localparam int DEF_SETUP_CYC    = 4;
   localparam int DEF_PULSE_CYC    = 4;
   localparam int DEF_GAP_CYC      = 8;
   localparam int DEF_LOCK_TIMEOUT = 4096;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/pll_phase_timer.sv
// Loadable down-counter with a zero flag; one instance times every sequencer interval.
module pll_phase_timer #(
   parameter int W = 13
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequencer that turns "shift output X by N steps" requests into timed PHASESTEP pulses
// and tracks the phase position of each PLL output.
module pll_phase_ctrl
   import pll_phase_pkg::*;
#(
   parameter int STEP_W       = DEF_STEP_W,
   parameter int POS_W        = DEF_POS_W,
   parameter int PHASE_MOD    = DEF_PHASE_MOD,
   parameter int SETUP_CYC    = DEF_SETUP_CYC,
   parameter int PULSE_CYC    = DEF_PULSE_CYC,
   parameter int GAP_CYC      = DEF_GAP_CYC,
   parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               pll_locked,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_sel,
   input  logic               req_dir,
   input  logic [STEP_W-1:0]  req_steps,
   output logic [1:0]         phasesel,
   output logic               phasedir,
   output logic               phasestep,
   output logic               phaseloadreg,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [4*POS_W-1:0] phase_pos
);

   localparam int TMR_W = $clog2(max4(LOCK_TIMEOUT, SETUP_CYC, PULSE_CYC, GAP_CYC)) + 1;

   state_e            state_q, state_d;
   logic [1:0]        phasesel_q;
   logic              phasedir_q;
   logic              phasestep_q;
   logic [STEP_W-1:0] rem_q;
   logic              err_q;
   logic [POS_W-1:0]  pos_q [4];

   logic              accept;
   logic              step_evt;
   logic              timeout;
   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_val;
   logic              tmr_zero;

   function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] pos, input logic dir);
      if (!dir) return (pos == POS_W'(PHASE_MOD - 1)) ? '0 : pos + POS_W'(1);
      else      return (pos == '0) ? POS_W'(PHASE_MOD - 1) : pos - POS_W'(1);
   endfunction

   pll_phase_timer #(.W(TMR_W)) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   assign req_ready = (state_q == ST_IDLE) & pll_locked & ~reset;
   assign accept    = req_valid & req_ready;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      step_evt = 1'b0;
      timeout  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (req_steps != '0) begin
                  state_d  = ST_SETUP;
                  tmr_load = 1'b1;
                  tmr_val  = TMR_W'(SETUP_CYC - 1);
               end else begin
                  state_d = ST_FINISH;
               end
            end
         end
         ST_SETUP: begin
            if (tmr_zero) begin
               state_d  = ST_PULSE;
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(PULSE_CYC - 1);
            end
         end
         ST_PULSE: begin
            if (tmr_zero) begin
               state_d  = ST_GAP;
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(GAP_CYC - 1);
               step_evt = 1'b1;
            end
         end
         ST_GAP, ST_LOCKWAIT: begin
            if (pll_locked && (tmr_zero || state_q == ST_LOCKWAIT)) begin
               if (rem_q != '0) begin
                  state_d  = ST_SETUP;
                  tmr_load = 1'b1;
                  tmr_val  = TMR_W'(SETUP_CYC - 1);
               end else begin
                  state_d = ST_FINISH;
               end
            end else if (tmr_zero && state_q == ST_GAP) begin
               state_d  = ST_LOCKWAIT;
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(LOCK_TIMEOUT - 1);
            end else if (tmr_zero) begin
               // lock never came back: abandon the rest of the request
               state_d = ST_FINISH;
               timeout = 1'b1;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // NOTE: position registers are part of the observable state, so they are reset with everything else.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         phasesel_q  <= '0;
         phasedir_q  <= 1'b1;
         phasestep_q <= 1'b1;
         rem_q       <= '0;
         err_q       <= 1'b0;
         for (int k = 0; k < 4; k++) pos_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         phasestep_q <= (state_d != ST_PULSE);
         if (accept) begin
            rem_q <= req_steps;
            err_q <= 1'b0;
            if (req_steps != '0) begin
               phasesel_q <= req_sel;
               phasedir_q <= req_dir;
            end
         end
         if (step_evt) begin
            rem_q             <= rem_q - STEP_W'(1);
            pos_q[phasesel_q] <= pos_step(pos_q[phasesel_q], phasedir_q);
         end
         if (timeout) begin
            rem_q <= '0;
            err_q <= 1'b1;
         end
      end
   end

   for (genvar k = 0; k < 4; k++) begin : g_pos
      assign phase_pos[k*POS_W +: POS_W] = pos_q[k];
   end

   assign phasesel     = phasesel_q;
   assign phasedir     = phasedir_q;
   assign phasestep    = phasestep_q;
   assign phaseloadreg = 1'b1;
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_FINISH);
   assign err          = err_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Scoreboard bench for pll_phase_ctrl: requests push expectations, a negedge monitor checks them.
module tb_pll_phase_ctrl;

   localparam int POS_W = 6;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              pll_locked = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [1:0]        req_sel = '0;
   logic              req_dir = 1'b0;
   logic [5:0]        req_steps = '0;
   logic [1:0]        phasesel;
   logic              phasedir;
   logic              phasestep;
   logic              phaseloadreg;
   logic              busy;
   logic              done;
   logic              err;
   logic [4*POS_W-1:0] phase_pos;

   pll_phase_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .pll_locked   (pll_locked),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_sel      (req_sel),
      .req_dir      (req_dir),
      .req_steps    (req_steps),
      .phasesel     (phasesel),
      .phasedir     (phasedir),
      .phasestep    (phasestep),
      .phaseloadreg (phaseloadreg),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .phase_pos    (phase_pos)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int         acc;
      logic [1:0] sel;
      logic       dir;
      int         n;
      int         done_rel;
      logic       err;
      logic [5:0] pos;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_err = 0;
   int   last_acc = 0;

   task automatic check(input string name, input longint act, input longint expv);
      n_checks++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic logic [5:0] pos_of(input int k);
      return phase_pos[k*POS_W +: POS_W];
   endfunction

   // Monitor: pulse shape, sel/dir during pulses, and request completion
   int   low_cnt = 0;
   int   pulses = 0;
   int   rel_m;
   exp_t e;
   always @(negedge clock) begin
      if (reset) begin
         low_cnt = 0;
         pulses  = 0;
      end else begin
         if (!phasestep) begin
            if (low_cnt == 0) begin
               if (sb_q.size() == 0) begin
                  check("pulse_without_request", 1, 0);
               end else begin
                  check("pulse_sel", phasesel, sb_q[0].sel);
                  check("pulse_dir", phasedir, sb_q[0].dir);
                  if (pulses == 0) check("first_pulse_cycle", cyc - sb_q[0].acc + 1, 5);
               end
            end
            low_cnt++;
         end else if (low_cnt != 0) begin
            check("pulse_width", low_cnt, 4);
            pulses++;
            low_cnt = 0;
         end
         if (done) begin
            if (sb_q.size() == 0) begin
               check("done_without_request", 1, 0);
            end else begin
               e = sb_q.pop_front();
               rel_m = cyc - e.acc + 1;
               if (e.done_rel >= 0) check("done_cycle", rel_m, e.done_rel);
               check("pulse_count", pulses, e.n);
               check("err_at_done", err, e.err);
               check("pos_at_done", pos_of(e.sel), e.pos);
            end
            pulses = 0;
         end
      end
   end

   task automatic issue(input logic [1:0] sel, input logic dir, input logic [5:0] steps,
                        input int n, input int done_rel, input logic e_err, input logic [5:0] e_pos);
      exp_t x;
      int   w;
      w = 0;
      @(negedge clock);
      while (!req_ready && w < 300) begin
         @(negedge clock);
         w++;
      end
      if (!req_ready) begin
         check("ready_wait_expired", 0, 1);
         return;
      end
      req_valid = 1'b1;
      req_sel   = sel;
      req_dir   = dir;
      req_steps = steps;
      @(posedge clock);
      #1;
      last_acc   = cyc;
      x.acc      = cyc;
      x.sel      = sel;
      x.dir      = dir;
      x.n        = n;
      x.done_rel = done_rel;
      x.err      = e_err;
      x.pos      = e_pos;
      sb_q.push_back(x);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int w;
      w = 0;
      while (sb_q.size() != 0 && w < budget) begin
         @(negedge clock);
         w++;
      end
      if (sb_q.size() != 0) begin
         check("completion_wait_expired", 0, 1);
         sb_q.delete();
      end
   endtask

   task automatic wait_rel(input int rel);
      int w;
      w = 0;
      @(negedge clock);
      while ((cyc - last_acc + 1) != rel && w < 200) begin
         @(negedge clock);
         w++;
      end
   endtask

   initial begin
      // reset state (lock high, but reset must still hold ready low)
      pll_locked = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_phasesel", phasesel, 0);
      check("rst_phasedir", phasedir, 1);
      check("rst_phasestep", phasestep, 1);
      check("rst_phaseloadreg", phaseloadreg, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_phase_pos", phase_pos, 0);
      check("rst_ready", req_ready, 0);
      reset = 1'b0;
      #1;
      check("ready_after_reset", req_ready, 1);

      // three advance steps on CLKOS
      issue(2'd0, 1'b0, 6'd3, 3, 49, 1'b0, 6'd3);
      wait_idle(200);

      // wrap both ways on CLKOS2, then a full turn
      issue(2'd1, 1'b1, 6'd1, 1, 17, 1'b0, 6'd47);
      wait_idle(100);
      issue(2'd1, 1'b0, 6'd1, 1, 17, 1'b0, 6'd0);
      wait_idle(100);
      issue(2'd1, 1'b0, 6'd48, 48, 769, 1'b0, 6'd0);
      wait_idle(1000);

      // zero-step request: done at T+1, busy one cycle, no pulses
      issue(2'd2, 1'b0, 6'd0, 0, 1, 1'b0, 6'd0);
      @(negedge clock);
      check("zero_step_busy_cycle1", busy, 1);
      @(negedge clock);
      check("zero_step_busy_cycle2", busy, 0);
      wait_idle(10);

      // lock lost during 2nd pulse (rel 22), restored at rel 122 -> third step at rel 123
      issue(2'd3, 1'b0, 6'd3, 3, 139, 1'b0, 6'd3);
      wait_rel(22);
      pll_locked = 1'b0;
      repeat (50) @(negedge clock);
      check("lockwait_busy", busy, 1);
      check("lockwait_ready", req_ready, 0);
      repeat (50) @(negedge clock);
      pll_locked = 1'b1;
      wait_idle(200);
      check("pos_after_lockwait", phase_pos, 24'h0C0003);

      // lock timeout after the first of five retard steps on CLKOS
      issue(2'd0, 1'b1, 6'd5, 1, 4113, 1'b1, 6'd2);
      wait_rel(10);
      pll_locked = 1'b0;
      wait_idle(5000);
      repeat (5) @(negedge clock);
      check("timeout_err_sticky", err, 1);
      check("timeout_ready_low", req_ready, 0);
      check("timeout_pos_vector", phase_pos, 24'h0C0002);
      pll_locked = 1'b1;
      #1;
      check("ready_on_relock", req_ready, 1);

      // request strobe held during a busy sequence must be ignored
      issue(2'd2, 1'b1, 6'd2, 2, 33, 1'b0, 6'd46);
      check("err_cleared_on_accept", err, 0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (done) begin
            req_valid = 1'b0;
            break;
         end
         if (i % 8 == 0) check("ready_low_while_busy", req_ready, 0);
         req_valid = 1'b1;
         req_sel   = 2'd3;
         req_steps = 6'd7;
      end
      req_valid = 1'b0;
      wait_idle(10);

      // synchronous reset in the middle of a pulse
      issue(2'd1, 1'b0, 6'd4, 0, -1, 1'b0, 6'd0);
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (!phasestep) break;
      end
      reset = 1'b1;
      @(negedge clock);
      sb_q.delete();
      check("abort_phasestep", phasestep, 1);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_phase_pos", phase_pos, 0);
      reset = 1'b0;

      // requests while unlocked are ignored
      pll_locked = 1'b0;
      req_valid  = 1'b1;
      req_sel    = 2'd0;
      req_steps  = 6'd3;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (i % 5 == 0) check("ready_low_unlocked", req_ready, 0);
      end
      check("idle_while_unlocked", busy, 0);
      req_valid  = 1'b0;
      pll_locked = 1'b1;
      repeat (40) @(negedge clock);
      check("final_phasestep_idle", phasestep, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
